execute_stage: RTL and testbench
================================

Name: execute_stage

Overview:
- EX stage of the 5-stage RV32I pipeline. Sits directly downstream of the decode stage's ID/EX register and upstream of memory access.
- Selects forwarded operands, runs the ALU and resolves branches. Produces the branch redirect (PCSrcE, PCTargetE) back to fetch and the decode flush.
- Owns the EX/MEM pipeline register.

Parameters:
- XLEN, 32, datapath width.
- REG_ADDR_W, 5, register index width.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  asynchronous active-low reset
- RegWriteE, ALUSrcE, MemWriteE, MemReadE, ResultSrcE, BranchE  in  1 each  ID/EX control bits
- ALUControlE  in  3  ALU operation
- RD1_E, RD2_E, Imm_Ext_E  in  XLEN  register operands, extended immediate
- RD_E  in  REG_ADDR_W  destination register
- PCE, PCPlus4E  in  XLEN  instruction PC, PC+4
- ForwardAE, ForwardBE  in  2  forwarding selects from the hazard unit
- ResultW  in  XLEN  writeback result (forward source)
- PCSrcE  out  1  branch taken; redirects fetch and flushes decode
- PCTargetE  out  XLEN  branch target
- RegWriteM, MemWriteM, MemReadM, ResultSrcM  out  1 each  EX/MEM control
- RD_M  out  REG_ADDR_W  EX/MEM destination
- ALUResultM, WriteDataM, PCPlus4M  out  XLEN  EX/MEM data

Behaviour:
- Clock and reset: single clock domain; rst asynchronous, active-low.
- Reset state: every EX/MEM register output is 0. Combinational outputs follow inputs.
- Forwarding mux, applied per operand:
  - 00 selects RD1_E / RD2_E.
  - 01 selects ResultW.
  - 10 selects ALUResultM, taken internally from this block's own register.
  - 11 is reserved and behaves as 00.
- SrcA = forwarded A.
- SrcB = Imm_Ext_E when ALUSrcE=1, else forwarded B.
- WriteData (pre-register) = forwarded B, always, regardless of ALUSrcE.
- ALUControlE encoding:
  - 000 ADD, 001 SUB, 010 AND, 011 OR
  - 100 XOR, 101 SLT (signed, result 0 or 1)
  - 110 SLL, 111 SRL
- ALU arithmetic rules:
  - Shifts use SrcB[4:0] only.
  - ADD/SUB wrap modulo 2^XLEN; overflow is not flagged.
- Branch resolution (combinational, same cycle as EX):
  - Zero = (ALU result == 0).
  - PCSrcE = BranchE & Zero. Branches are BEQ via SUB.
  - PCTargetE = PCE + Imm_Ext_E, modulo 2^XLEN; wraps at 0xFFFFFFFC + 8 = 0x4.
- Flushed bubble from decode: all control inputs are 0, so PCSrcE=0. No register or memory write propagates; data fields are don't-care.
- EX/MEM register:
  - Captures on every posedge clk.
  - Latency EX to M is one cycle.
  - No stall or flush input: EX is never stalled, and bubbles arrive already cleared.
- Forwarding from ALUResultM always uses the value registered the previous cycle. Forwarding from ResultW uses the current input. Back-to-back dependent instructions therefore see the correct value without a combinational loop.
- Reset mid-operation: outputs go to 0 immediately. The first post-reset edge loads whatever is on the inputs.
- BranchE with RegWriteE=1 is legal: the register write still propagates to M.

Decomposition:
- Shared package pipeline_pkg holds:
  - ALU_ADD..ALU_SRL constants (3-bit).
  - FWD_RF, FWD_WB, FWD_MEM constants (2-bit).
  - XLEN and REG_ADDR_W defaults.
- One sub-module, alu: SrcA, SrcB, ALUControl in; Result and Zero out; purely combinational.
- Forward muxes, branch adder and EX/MEM register stay in execute_stage.

Test Plan:
- Reset: hold rst=0 with arbitrary inputs, then release → all M outputs 0 before the first edge; after one edge, RegWriteM, RD_M and ALUResultM reflect the inputs.
- ADD with immediate: RD1_E=5, Imm_Ext_E=0xFFFFFFFF, ALUSrcE=1, ALUControlE=000 → ALUResultM=4 one cycle later. Repeat with SUB, RD1_E=0, RD2_E=1 → 0xFFFFFFFF. Repeat with SLT, 0xFFFFFFFF vs 1 → 1.
- Forwarding: cycle 1 ADD giving 0x10. Cycle 2: ForwardAE=10, RD1_E=0xDEAD, RD2_E=1 → ALUResultM=0x11. Cycle 3: ForwardBE=01, ResultW=7, ALUSrcE=1, MemWriteE=1 → WriteDataM=7 (the ALU still uses the immediate). ForwardAE=11 → behaves as 00.
- Branch taken: BranchE=1, SUB, RD1_E=RD2_E=0x42, PCE=0x100, Imm_Ext_E=0xFFFFFFF0 → same cycle PCSrcE=1, PCTargetE=0xF0. Unequal operands → PCSrcE=0.
- Bubble: all control bits 0, RD1_E=RD2_E → PCSrcE=0; next cycle RegWriteM=0 and MemWriteM=0.
- Shift boundary: SLL with RD1_E=1, RD2_E=0x21 → 2 (only SrcB[4:0] used). SRL with RD1_E=0x80000000, RD2_E=31 → 1.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared definitions for the RV32I pipeline: datapath widths, ALU operation
// codes and forwarding-select codes used by the execute stage and the hazard unit.
package pipeline_pkg;

    localparam int XLEN_DEFAULT       = 32;
    localparam int REG_ADDR_W_DEFAULT = 5;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_XOR = 3'b100,
        ALU_SLT = 3'b101,
        ALU_SLL = 3'b110,
        ALU_SRL = 3'b111
    } alu_op_e;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

endpackage : pipeline_pkg

// File: rtl/alu.sv
// Combinational RV32I ALU: eight operations selected by ALUControl, plus a
// Zero flag used by the execute stage for BEQ-style branch resolution.
module alu
    import pipeline_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic [XLEN-1:0] SrcA,
    input  logic [XLEN-1:0] SrcB,
    input  logic [2:0]      ALUControl,
    output logic [XLEN-1:0] Result,
    output logic            Zero
);

    localparam int SHAMT_W = $clog2(XLEN);

    logic [SHAMT_W-1:0] shamt;
    assign shamt = SrcB[SHAMT_W-1:0];

    always_comb begin
        // NOTE: default assignment first so no path through the case leaves Result unassigned (no latch).
        Result = '0;
        case (alu_op_e'(ALUControl))
            ALU_ADD: Result = SrcA + SrcB;
            ALU_SUB: Result = SrcA - SrcB;
            ALU_AND: Result = SrcA & SrcB;
            ALU_OR:  Result = SrcA | SrcB;
            ALU_XOR: Result = SrcA ^ SrcB;
            ALU_SLT: Result = {{(XLEN-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
            ALU_SLL: Result = SrcA << shamt;
            ALU_SRL: Result = SrcA >> shamt;
            default: Result = '0;
        endcase
    end

    assign Zero = (Result == '0);

endmodule : alu

// File: rtl/execute_stage.sv
// EX stage of the 5-stage RV32I pipeline: operand forwarding, ALU, branch
// resolution and the EX/MEM pipeline register.
module execute_stage
    import pipeline_pkg::*;
#(
    parameter int XLEN       = XLEN_DEFAULT,
    parameter int REG_ADDR_W = REG_ADDR_W_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  RegWriteE,
    input  logic                  ALUSrcE,
    input  logic                  MemWriteE,
    input  logic                  MemReadE,
    input  logic                  ResultSrcE,
    input  logic                  BranchE,
    input  logic [2:0]            ALUControlE,
    input  logic [XLEN-1:0]       RD1_E,
    input  logic [XLEN-1:0]       RD2_E,
    input  logic [XLEN-1:0]       Imm_Ext_E,
    input  logic [REG_ADDR_W-1:0] RD_E,
    input  logic [XLEN-1:0]       PCE,
    input  logic [XLEN-1:0]       PCPlus4E,
    input  logic [1:0]            ForwardAE,
    input  logic [1:0]            ForwardBE,
    input  logic [XLEN-1:0]       ResultW,
    output logic                  PCSrcE,
    output logic [XLEN-1:0]       PCTargetE,
    output logic                  RegWriteM,
    output logic                  MemWriteM,
    output logic                  MemReadM,
    output logic                  ResultSrcM,
    output logic [REG_ADDR_W-1:0] RD_M,
    output logic [XLEN-1:0]       ALUResultM,
    output logic [XLEN-1:0]       WriteDataM,
    output logic [XLEN-1:0]       PCPlus4M
);

    logic [XLEN-1:0] src_a, fwd_b, src_b, alu_result;
    logic            alu_zero;

    logic                  reg_write_q, mem_write_q, mem_read_q, result_src_q;
    logic [REG_ADDR_W-1:0] rd_q;
    logic [XLEN-1:0]       alu_result_q, write_data_q, pc_plus4_q;

    // The MEM-stage source is this block's own register, so there is no comb loop.
    always_comb begin
        src_a = RD1_E;
        case (ForwardAE)
            FWD_RF:  src_a = RD1_E;
            FWD_WB:  src_a = ResultW;
            FWD_MEM: src_a = alu_result_q;
            default: src_a = RD1_E;
        endcase
    end

    always_comb begin
        fwd_b = RD2_E;
        case (ForwardBE)
            FWD_RF:  fwd_b = RD2_E;
            FWD_WB:  fwd_b = ResultW;
            FWD_MEM: fwd_b = alu_result_q;
            default: fwd_b = RD2_E;
        endcase
    end

    assign src_b = ALUSrcE ? Imm_Ext_E : fwd_b;

    alu #(.XLEN(XLEN)) u_alu (
        .SrcA       (src_a),
        .SrcB       (src_b),
        .ALUControl (ALUControlE),
        .Result     (alu_result),
        .Zero       (alu_zero)
    );

    assign PCSrcE    = BranchE & alu_zero;
    assign PCTargetE = PCE + Imm_Ext_E;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            reg_write_q  <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_read_q   <= 1'b0;
            result_src_q <= 1'b0;
            rd_q         <= '0;
            alu_result_q <= '0;
            write_data_q <= '0;
            pc_plus4_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values, independent of statement order.
            reg_write_q  <= RegWriteE;
            mem_write_q  <= MemWriteE;
            mem_read_q   <= MemReadE;
            result_src_q <= ResultSrcE;
            rd_q         <= RD_E;
            alu_result_q <= alu_result;
            write_data_q <= fwd_b;
            pc_plus4_q   <= PCPlus4E;
        end
    end

    assign RegWriteM  = reg_write_q;
    assign MemWriteM  = mem_write_q;
    assign MemReadM   = mem_read_q;
    assign ResultSrcM = result_src_q;
    assign RD_M       = rd_q;
    assign ALUResultM = alu_result_q;
    assign WriteDataM = write_data_q;
    assign PCPlus4M   = pc_plus4_q;

endmodule : execute_stage

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage: directed vector table, reset
// sequences and randomized traffic against a behavioural reference model.
module tb_execute_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        RegWriteE, ALUSrcE, MemWriteE, MemReadE, ResultSrcE, BranchE;
    logic [2:0]  ALUControlE;
    logic [31:0] RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, ResultW;
    logic [4:0]  RD_E;
    logic [1:0]  ForwardAE, ForwardBE;
    logic        PCSrcE;
    logic [31:0] PCTargetE;
    logic        RegWriteM, MemWriteM, MemReadM, ResultSrcM;
    logic [4:0]  RD_M;
    logic [31:0] ALUResultM, WriteDataM, PCPlus4M;

    execute_stage #(.XLEN(32), .REG_ADDR_W(5)) dut (
        .clk(clk), .rst(rst),
        .RegWriteE(RegWriteE), .ALUSrcE(ALUSrcE), .MemWriteE(MemWriteE),
        .MemReadE(MemReadE), .ResultSrcE(ResultSrcE), .BranchE(BranchE),
        .ALUControlE(ALUControlE), .RD1_E(RD1_E), .RD2_E(RD2_E),
        .Imm_Ext_E(Imm_Ext_E), .RD_E(RD_E), .PCE(PCE), .PCPlus4E(PCPlus4E),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .ResultW(ResultW),
        .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
        .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .MemReadM(MemReadM),
        .ResultSrcM(ResultSrcM), .RD_M(RD_M), .ALUResultM(ALUResultM),
        .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        regw, alusrc, memw, memr, ressrc, branch;
        logic [2:0]  ctl;
        logic [1:0]  fa, fb;
        logic [4:0]  rd;
        logic [31:0] rd1, rd2, imm, pc, resw;
        logic [31:0] e_alu, e_wd, e_tgt;
        logic        e_pcsrc;
    } vec_t;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] prev_alu;   // what ALUResultM must currently hold
    vec_t        tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        int sa, sb;
        sa = int'(a);
        sb = int'(b);
        case (op)
            3'd0: return a + b;
            3'd1: return a + ~b + 32'd1;
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: return a ^ b;
            3'd5: return (sa < sb) ? 32'd1 : 32'd0;
            3'd6: return a << (b % 32);
            default: return a >> (b % 32);
        endcase
    endfunction

    function automatic logic [31:0] pick(input logic [1:0] sel, input logic [31:0] rf, input logic [31:0] wb);
        if (sel == 2'd1) return wb;
        if (sel == 2'd2) return prev_alu;
        return rf;
    endfunction

    function automatic vec_t model(input vec_t v);
        vec_t        e;
        logic [31:0] a, b;
        e       = v;
        a       = pick(v.fa, v.rd1, v.resw);
        b       = pick(v.fb, v.rd2, v.resw);
        e.e_wd  = b;
        e.e_alu = ref_alu(v.ctl, a, v.alusrc ? v.imm : b);
        e.e_pcsrc = v.branch && (e.e_alu == 32'd0);
        e.e_tgt = v.pc + v.imm;
        return e;
    endfunction

    function automatic vec_t mk(input string name, input logic [2:0] ctl, input logic alusrc,
                                input logic [1:0] fa, input logic [1:0] fb,
                                input logic [31:0] rd1, input logic [31:0] rd2,
                                input logic [31:0] imm, input logic [31:0] resw,
                                input logic [31:0] pc, input logic regw, input logic branch,
                                input logic memw, input logic [31:0] e_alu,
                                input logic [31:0] e_wd, input logic e_pcsrc,
                                input logic [31:0] e_tgt);
        vec_t v;
        v.name = name; v.ctl = ctl; v.alusrc = alusrc; v.fa = fa; v.fb = fb;
        v.rd1 = rd1; v.rd2 = rd2; v.imm = imm; v.resw = resw; v.pc = pc;
        v.regw = regw; v.branch = branch; v.memw = memw; v.memr = 1'b0; v.ressrc = 1'b0;
        v.rd = 5'(tbl.size() + 1);
        v.e_alu = e_alu; v.e_wd = e_wd; v.e_pcsrc = e_pcsrc; v.e_tgt = e_tgt;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        RegWriteE = v.regw;  ALUSrcE = v.alusrc; MemWriteE = v.memw;
        MemReadE = v.memr;   ResultSrcE = v.ressrc; BranchE = v.branch;
        ALUControlE = v.ctl; RD1_E = v.rd1; RD2_E = v.rd2; Imm_Ext_E = v.imm;
        RD_E = v.rd; PCE = v.pc; PCPlus4E = v.pc + 32'd4;
        ForwardAE = v.fa; ForwardBE = v.fb; ResultW = v.resw;
    endtask

    // Entered at posedge+1; returns at the following posedge+1.
    task automatic run(input vec_t v, input bit use_model);
        vec_t e;
        e = use_model ? model(v) : v;
        drive(v);
        #4;
        check({v.name, ".pcsrc"}, {31'd0, PCSrcE}, {31'd0, e.e_pcsrc});
        check({v.name, ".target"}, PCTargetE, e.e_tgt);
        @(posedge clk);
        #1;
        check({v.name, ".alu_m"}, ALUResultM, e.e_alu);
        check({v.name, ".wdata_m"}, WriteDataM, e.e_wd);
        check({v.name, ".ctrl_m"}, {28'd0, RegWriteM, MemWriteM, MemReadM, ResultSrcM},
              {28'd0, v.regw, v.memw, v.memr, v.ressrc});
        check({v.name, ".rd_m"}, {27'd0, RD_M}, {27'd0, v.rd});
        check({v.name, ".pc4_m"}, PCPlus4M, v.pc + 32'd4);
        prev_alu = e.e_alu;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;

        // Reset held with live inputs: registers must stay cleared.
        rst = 1'b0;
        v = mk("rst", 3'd0, 1'b0, 2'd0, 2'd0, 32'd3, 32'd4, 32'h0, 32'h0, 32'h40,
               1'b1, 1'b0, 1'b1, 32'd7, 32'd4, 1'b0, 32'h40);
        v.rd = 5'd5;
        drive(v);
        repeat (2) @(posedge clk);
        #1;
        check("rst_hold.alu_m", ALUResultM, 32'd0);
        check("rst_hold.wdata_m", WriteDataM, 32'd0);
        check("rst_hold.pc4_m", PCPlus4M, 32'd0);
        check("rst_hold.ctrl_m", {27'd0, RegWriteM, MemWriteM, MemReadM, ResultSrcM, 1'b0}, 32'd0);
        check("rst_hold.rd_m", {27'd0, RD_M}, 32'd0);
        rst = 1'b1;
        #2;
        check("rst_rel.alu_m", ALUResultM, 32'd0);
        check("rst_rel.regw_m", {31'd0, RegWriteM}, 32'd0);
        @(posedge clk);
        #1;
        check("rst_first.regw_m", {31'd0, RegWriteM}, 32'd1);
        check("rst_first.rd_m", {27'd0, RD_M}, 32'd5);
        check("rst_first.alu_m", ALUResultM, 32'd7);
        prev_alu = 32'd7;

        //        name          ctl  src fa   fb   rd1           rd2           imm           resw     pc            rw  br  mw  e_alu         e_wd          pcs e_tgt
        tbl.push_back(mk("add_imm",   3'd0, 1, 2'd0, 2'd0, 32'd5,        32'd0,        32'hFFFFFFFF, 32'd0,   32'h200,      1,  0,  0,  32'd4,        32'd0,        0,  32'h1FF));
        tbl.push_back(mk("sub_neg",   3'd1, 0, 2'd0, 2'd0, 32'd0,        32'd1,        32'd0,        32'd0,   32'h200,      1,  0,  0,  32'hFFFFFFFF, 32'd1,        0,  32'h200));
        tbl.push_back(mk("slt_neg",   3'd5, 0, 2'd0, 2'd0, 32'hFFFFFFFF, 32'd1,        32'd0,        32'd0,   32'h200,      1,  0,  0,  32'd1,        32'd1,        0,  32'h200));
        tbl.push_back(mk("fwd_setup", 3'd0, 0, 2'd0, 2'd0, 32'd8,        32'd8,        32'd0,        32'd0,   32'h200,      1,  0,  0,  32'h10,       32'd8,        0,  32'h200));
        tbl.push_back(mk("fwd_mem_a", 3'd0, 0, 2'd2, 2'd0, 32'hDEAD,     32'd1,        32'd0,        32'd0,   32'h200,      1,  0,  0,  32'h11,       32'd1,        0,  32'h200));
        tbl.push_back(mk("fwd_wb_b",  3'd0, 1, 2'd0, 2'd1, 32'h100,      32'h55,       32'd4,        32'd7,   32'h200,      0,  0,  1,  32'h104,      32'd7,        0,  32'h204));
        tbl.push_back(mk("fwd_rsv",   3'd0, 0, 2'd3, 2'd3, 32'd3,        32'd2,        32'd0,        32'h999, 32'h200,      1,  0,  0,  32'd5,        32'd2,        0,  32'h200));
        tbl.push_back(mk("br_taken",  3'd1, 0, 2'd0, 2'd0, 32'h42,       32'h42,       32'hFFFFFFF0, 32'd0,   32'h100,      1,  1,  0,  32'd0,        32'h42,       1,  32'hF0));
        tbl.push_back(mk("br_not",    3'd1, 0, 2'd0, 2'd0, 32'h42,       32'h43,       32'hFFFFFFF0, 32'd0,   32'h100,      0,  1,  0,  32'hFFFFFFFF, 32'h43,       0,  32'hF0));
        tbl.push_back(mk("br_wrap",   3'd1, 0, 2'd0, 2'd0, 32'd7,        32'd7,        32'd8,        32'd0,   32'hFFFFFFFC, 0,  1,  0,  32'd0,        32'd7,        1,  32'h4));
        tbl.push_back(mk("bubble",    3'd0, 0, 2'd0, 2'd0, 32'd0,        32'd0,        32'd0,        32'd0,   32'h200,      0,  0,  0,  32'd0,        32'd0,        0,  32'h200));
        tbl.push_back(mk("sll_wrap",  3'd6, 0, 2'd0, 2'd0, 32'd1,        32'h21,       32'd0,        32'd0,   32'h200,      1,  0,  0,  32'd2,        32'h21,       0,  32'h200));
        tbl.push_back(mk("srl_31",    3'd7, 0, 2'd0, 2'd0, 32'h80000000, 32'd31,       32'd0,        32'd0,   32'h200,      1,  0,  0,  32'd1,        32'd31,       0,  32'h200));
        tbl.push_back(mk("and",       3'd2, 0, 2'd0, 2'd0, 32'hF0F0,     32'hFF00,     32'd0,        32'd0,   32'h200,      1,  0,  0,  32'hF000,     32'hFF00,     0,  32'h200));
        tbl.push_back(mk("or",        3'd3, 0, 2'd0, 2'd0, 32'hF0F0,     32'hFF00,     32'd0,        32'd0,   32'h200,      1,  0,  0,  32'hFFF0,     32'hFF00,     0,  32'h200));
        tbl.push_back(mk("xor",       3'd4, 0, 2'd0, 2'd0, 32'hFFFF,     32'h0F0F,     32'd0,        32'd0,   32'h200,      1,  0,  0,  32'hF0F0,     32'h0F0F,     0,  32'h200));
        tbl.push_back(mk("fwd_mem_b", 3'd0, 0, 2'd0, 2'd2, 32'h10,       32'd0,        32'd0,        32'd0,   32'h200,      1,  0,  0,  32'hF100,     32'hF0F0,     0,  32'h200));
        tbl.push_back(mk("slt_pos",   3'd5, 0, 2'd0, 2'd0, 32'd1,        32'hFFFFFFFF, 32'd0,        32'd0,   32'h200,      1,  0,  0,  32'd0,        32'hFFFFFFFF, 0,  32'h200));
        tbl.push_back(mk("pre_rst",   3'd0, 0, 2'd0, 2'd0, 32'd1,        32'd1,        32'd0,        32'd0,   32'h300,      1,  0,  1,  32'd2,        32'd1,        0,  32'h300));

        foreach (tbl[i]) run(tbl[i], 1'b0);

        // Asynchronous reset mid-operation, then the first edge reloads.
        v = mk("mid_rst", 3'd0, 1'b0, 2'd0, 2'd0, 32'h20, 32'h3, 32'd0, 32'd0, 32'h400,
               1'b1, 1'b0, 1'b0, 32'h23, 32'h3, 1'b0, 32'h400);
        v.rd = 5'd9;
        drive(v);
        #1 rst = 1'b0;
        #1;
        check("mid_rst.alu_m", ALUResultM, 32'd0);
        check("mid_rst.ctrl_m", {28'd0, RegWriteM, MemWriteM, MemReadM, ResultSrcM}, 32'd0);
        #2 rst = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_first.alu_m", ALUResultM, 32'h23);
        check("mid_rst_first.rd_m", {27'd0, RD_M}, 32'd9);
        check("mid_rst_first.regw_m", {31'd0, RegWriteM}, 32'd1);
        prev_alu = 32'h23;

        for (int i = 0; i < 300; i++) begin
            v.name   = "rnd";
            v.regw   = 1'($urandom); v.alusrc = 1'($urandom); v.memw   = 1'($urandom);
            v.memr   = 1'($urandom); v.ressrc = 1'($urandom); v.branch = 1'($urandom);
            v.ctl    = 3'($urandom); v.fa     = 2'($urandom); v.fb     = 2'($urandom);
            v.rd     = 5'($urandom);
            v.rd1    = $urandom;     v.rd2    = $urandom;     v.imm    = $urandom;
            v.pc     = $urandom & 32'hFFFFFFFC;
            v.resw   = $urandom;
            if ($urandom_range(3) == 0) begin
                v.rd2 = v.rd1; v.ctl = 3'd1; v.alusrc = 1'b0; v.fb = v.fa;
            end
            if ($urandom_range(7) == 0) v.rd2 = 32'($urandom_range(63));
            run(v, 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_execute_stage
